// File: rtl/fpadd_pkg.sv
// Shared types and constants for the single-precision adder normalize/round stage.
package fpadd_pkg;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam int unsigned EXT_W   = 27;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized {1.mant, G, R, S} extended magnitude.
module fp_round_rne #(
    parameter int unsigned MANT_W = 23
) (
    input  logic [MANT_W+3:0] i_ext,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_exp_inc,
    output logic              o_inexact
);

    logic [MANT_W:0]   w_sig;
    logic              w_g;
    logic              w_r;
    logic              w_s;
    logic              w_up;
    logic [MANT_W+1:0] w_sum;

    assign w_sig = i_ext[MANT_W+3:3];
    assign w_g   = i_ext[2];
    assign w_r   = i_ext[1];
    assign w_s   = i_ext[0];
    assign w_up  = w_g & (w_r | w_s | w_sig[0]);
    assign w_sum = {1'b0, w_sig} + {{(MANT_W+1){1'b0}}, w_up};

    // A carry out leaves 10..0, so the stored bits are zero after the renormalizing shift.
    assign o_exp_inc = w_sum[MANT_W+1];
    assign o_mant    = w_sum[MANT_W+1] ? w_sum[MANT_W:1] : w_sum[MANT_W-1:0];
    assign o_inexact = w_g | w_r | w_s;

endmodule

// File: rtl/fp_add_normalize.sv
// FP adder add/normalize/round stage with valid/ready handshake.
// Define FPADD_FLAGS_EN to build the overflow/underflow/inexact flag logic.
module fp_add_normalize
    import fpadd_pkg::*;
#(
    parameter int unsigned MANT_W = 23,
    parameter int unsigned EXP_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    signA,
    input  logic                    signB,
    input  logic [MANT_W:0]         alignedMantissaA,
    input  logic [MANT_W:0]         alignedMantissaB,
    input  logic                    guardBit,
    input  logic                    roundBit,
    input  logic                    stickyBit,
    input  logic [EXP_W-1:0]        exponentIn,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);

    localparam int unsigned XW = MANT_W + 4;
    localparam int unsigned WW = XW + 1;
    localparam int unsigned EW = EXP_W + 2;
    localparam logic [EW-1:0] EXP_ONE = EW'(1);
    localparam logic [EW-1:0] EXP_INF = EW'((1 << EXP_W) - 1);

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [MANT_W:0]     r_mant_a;
    logic [MANT_W:0]     r_mant_b;
    logic [2:0]          r_grs;
    logic [EW-1:0]       r_exp;
    logic [WW-1:0]       r_w;
    logic                r_sign;
    logic [EXP_W+MANT_W:0] r_result;

    logic [XW-1:0]       w_ext_a;
    logic [XW-1:0]       w_ext_b;
    logic                w_a_ge_b;
    logic [WW-1:0]       w_sum;
    logic                w_sum_sign;
    logic                w_sum_zero;
    logic                w_norm_stop;
    logic                w_flush;
    logic [MANT_W-1:0]   w_rnd_mant;
    logic                w_rnd_inc;
    logic                w_rnd_inexact;
    logic [EW-1:0]       w_exp_rnd;
    logic                w_ovf;

    // The shifted operand is the one whose hidden bit is clear; only it carries G/R/S.
    assign w_ext_a  = r_mant_a[MANT_W] ? {r_mant_a, 3'b000} : {r_mant_a, r_grs};
    assign w_ext_b  = r_mant_b[MANT_W] ? {r_mant_b, 3'b000} : {r_mant_b, r_grs};
    assign w_a_ge_b = (w_ext_a >= w_ext_b);

    always_comb begin
        w_sum      = {1'b0, w_ext_a} + {1'b0, w_ext_b};
        w_sum_sign = r_sign_a;
        if (r_sign_a ^ r_sign_b) begin
            if (w_a_ge_b) begin
                w_sum      = {1'b0, w_ext_a - w_ext_b};
                w_sum_sign = r_sign_a;
            end else begin
                w_sum      = {1'b0, w_ext_b - w_ext_a};
                w_sum_sign = r_sign_b;
            end
        end
    end

    assign w_sum_zero  = (w_sum == '0);
    assign w_norm_stop = r_w[WW-1] | r_w[XW-1] | (r_exp == EXP_ONE);
    assign w_flush     = (r_state == NORM) & ~r_w[WW-1] & ~r_w[XW-1] & (r_exp == EXP_ONE);

    fp_round_rne #(
        .MANT_W (MANT_W)
    ) u_round (
        .i_ext     (r_w[XW-1:0]),
        .o_mant    (w_rnd_mant),
        .o_exp_inc (w_rnd_inc),
        .o_inexact (w_rnd_inexact)
    );

    assign w_exp_rnd = r_exp + {{(EW-1){1'b0}}, w_rnd_inc};
    assign w_ovf     = (w_exp_rnd >= EXP_INF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_state_nx = ADD;
            ADD:     w_state_nx = w_sum_zero ? ROUND : NORM;
            NORM:    if (w_norm_stop) w_state_nx = ROUND;
            ROUND:   w_state_nx = DONE;
            DONE:    if (out_ready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mant_a <= '0;
            r_mant_b <= '0;
            r_grs    <= '0;
            r_exp    <= '0;
            r_w      <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign_a <= signA;
                        r_sign_b <= signB;
                        r_mant_a <= alignedMantissaA;
                        r_mant_b <= alignedMantissaB;
                        r_grs    <= {guardBit, roundBit, stickyBit};
                        r_exp    <= {2'b00, exponentIn};
                    end
                end
                ADD: begin
                    r_w <= w_sum;
                    if (w_sum_zero) begin
                        r_sign <= 1'b0;
                        r_exp  <= '0;
                    end else begin
                        r_sign <= w_sum_sign;
                    end
                end
                NORM: begin
                    if (r_w[WW-1]) begin
                        r_w   <= {1'b0, r_w[WW-1:2], r_w[1] | r_w[0]};
                        r_exp <= r_exp + EXP_ONE;
                    end else if (r_w[XW-1]) begin
                        r_w <= r_w;
                    end else if (r_exp == EXP_ONE) begin
                        r_w   <= '0;
                        r_exp <= '0;
                    end else begin
                        r_w   <= {r_w[WW-2:0], 1'b0};
                        r_exp <= r_exp - EXP_ONE;
                    end
                end
                ROUND: begin
                    if (w_ovf) r_result <= {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                    else       r_result <= {r_sign, w_exp_rnd[EXP_W-1:0], w_rnd_mant};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

`ifdef FPADD_FLAGS_EN
    logic r_ovf;
    logic r_unf;
    logic r_inx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_inx <= 1'b0;
        end else if ((r_state == IDLE) && in_valid) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_inx <= 1'b0;
        end else if (w_flush) begin
            r_unf <= 1'b1;
        end else if (r_state == ROUND) begin
            // A flushed value is always nonzero, so a set underflow alone implies inexact.
            r_ovf <= w_ovf;
            r_inx <= w_rnd_inexact | w_ovf | r_unf;
        end
    end

    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign inexact   = r_inx;
`else
    logic w_unused_flags;
    assign w_unused_flags = w_rnd_inexact | w_flush;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
    assign inexact   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed-vector bench for fp_add_normalize with an arithmetic reference model.
module tb_fp_add_normalize;
    import fpadd_pkg::*;

`ifdef FPADD_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        signA;
    logic        signB;
    logic [23:0] alignedMantissaA;
    logic [23:0] alignedMantissaB;
    logic        guardBit;
    logic        roundBit;
    logic        stickyBit;
    logic [7:0]  exponentIn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_res;
    logic        m_ov;
    logic        m_un;
    logic        m_ix;

    fp_add_normalize #(
        .MANT_W (23),
        .EXP_W  (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .signA            (signA),
        .signB            (signB),
        .alignedMantissaA (alignedMantissaA),
        .alignedMantissaB (alignedMantissaB),
        .guardBit         (guardBit),
        .roundBit         (roundBit),
        .stickyBit        (stickyBit),
        .exponentIn       (exponentIn),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .overflow         (overflow),
        .underflow        (underflow),
        .inexact          (inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: exact integer add/sub, leading-one normalization, RNE rounding.
    function automatic void model(input logic [23:0] ma, input logic [23:0] mb,
                                  input logic sa, input logic sb, input logic [2:0] grs,
                                  input logic [7:0] e, output logic [31:0] res,
                                  output logic ov, output logic un, output logic ix,
                                  output int lat);
        longint a, b, mag, m, sig;
        int p, ee, shifts;
        logic sign;
        logic [2:0] low;
        a = longint'(ma) * 8 + (ma[23] ? 64'd0 : longint'(grs));
        b = longint'(mb) * 8 + (mb[23] ? 64'd0 : longint'(grs));
        if (sa == sb)    begin mag = a + b; sign = sa; end
        else if (a >= b) begin mag = a - b; sign = sa; end
        else             begin mag = b - a; sign = sb; end
        ov = 1'b0; un = 1'b0; ix = 1'b0;
        if (mag == 0) begin
            res = 32'h0; lat = 2;
            return;
        end
        p = 27;
        while (p > 0 && mag[p] == 1'b0) p--;
        ee = int'(e);
        shifts = 0;
        if (p == 27) begin
            m = (mag >> 1) | (mag & 64'd1);
            ee = ee + 1;
        end else begin
            shifts = 26 - p;
            if (shifts > ee - 1) begin
                lat = 3 + (ee - 1);
                res = {sign, 31'h0};
                un = 1'b1; ix = 1'b1;
                return;
            end
            m = mag << shifts;
            ee = ee - shifts;
        end
        lat = 3 + shifts;
        sig = m >> 3;
        low = m[2:0];
        if (low[2] && (low[1] || low[0] || sig[0])) sig = sig + 1;
        if (sig == (longint'(1) << 24)) begin
            sig = sig >> 1;
            ee = ee + 1;
        end
        ix = (low != 3'b000);
        if (ee >= 255) begin
            res = {sign, 8'hFF, 23'h0};
            ov = 1'b1; ix = 1'b1;
        end else begin
            res = {sign, ee[7:0], sig[22:0]};
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("result", result, m_res);
            check("overflow", {31'h0, overflow}, {31'h0, FL & m_ov});
            check("underflow", {31'h0, underflow}, {31'h0, FL & m_un});
            check("inexact", {31'h0, inexact}, {31'h0, FL & m_ix});
            check("in_ready_busy", {31'h0, in_ready}, 32'h0);
        end
    end

    task automatic start_op(input logic [23:0] ma, input logic [23:0] mb, input logic sa,
                            input logic sb, input logic [2:0] grs, input logic [7:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", {31'h0, in_ready}, 32'h1);
        alignedMantissaA = ma;
        alignedMantissaB = mb;
        signA = sa;
        signB = sb;
        {guardBit, roundBit, stickyBit} = grs;
        exponentIn = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [23:0] ma, input logic [23:0] mb, input logic sa,
                         input logic sb, input logic [2:0] grs, input logic [7:0] e,
                         input logic [31:0] lit_res, input int lit_lat,
                         input logic [2:0] lit_fl, input int hold);
        logic [31:0] r;
        logic o, u, x, got;
        int l, lat;
        model(ma, mb, sa, sb, grs, e, r, o, u, x, l);
        check("model_result", r, lit_res);
        check("model_flags", {29'h0, o, u, x}, {29'h0, lit_fl});
        check("model_latency", l, lit_lat);
        m_res = r; m_ov = o; m_un = u; m_ix = x;
        start_op(ma, mb, sa, sb, grs, e);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            got = out_valid;
        end
        check("latency", lat, l);
        if (got) begin
            repeat (hold) @(posedge clk);
            @(negedge clk) out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            check("out_valid_clear", {31'h0, out_valid}, 32'h0);
            check("in_ready_after", {31'h0, in_ready}, 32'h1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
        check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_result"}, result, 32'h0);
        check({tag, "_flags"}, {29'h0, overflow, underflow, inexact}, 32'h0);
    endtask

    initial begin
        fp32_t inf_pos;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        signA = 1'b0;
        signB = 1'b0;
        alignedMantissaA = '0;
        alignedMantissaB = '0;
        {guardBit, roundBit, stickyBit} = 3'b000;
        exponentIn = '0;
        m_res = '0; m_ov = 1'b0; m_un = 1'b0; m_ix = 1'b0;
        inf_pos = '{sign: 1'b0, exp: 8'hFF, mant: 23'h0};
        #3;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(24'h800000, 24'h800000, 1'b0, 1'b0, 3'b000, 8'd127, 32'h40000000, 3, 3'b000, 0);
        do_op(24'hC00000, 24'hA00000, 1'b0, 1'b1, 3'b000, 8'd127, 32'h3E800000, 5, 3'b000, 0);
        do_op(24'h800000, 24'h800000, 1'b0, 1'b1, 3'b000, 8'd127, 32'h00000000, 2, 3'b000, 0);
        do_op(24'h800000, 24'h000000, 1'b0, 1'b0, 3'b100, 8'd127, 32'h3F800000, 3, 3'b001, 0);
        do_op(24'h800001, 24'h000000, 1'b0, 1'b0, 3'b100, 8'd127, 32'h3F800002, 3, 3'b001, 0);
        do_op(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 3'b000, 8'd254, inf_pos, 3, 3'b101, 0);
        do_op(24'hA00000, 24'hC00000, 1'b0, 1'b1, 3'b000, 8'd127, 32'hBE800000, 5, 3'b000, 10);
        do_op(24'h800000, 24'h7FFFFF, 1'b0, 1'b1, 3'b000, 8'd127, 32'h34000000, 26, 3'b000, 0);
        do_op(24'h800000, 24'h7FFFFF, 1'b1, 1'b0, 3'b000, 8'd3, 32'h80000000, 5, 3'b011, 0);

        start_op(24'h800000, 24'h7FFFFF, 1'b0, 1'b1, 3'b000, 8'd127);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("midop_reset");
        @(negedge clk) rst_n = 1'b1;
        do_op(24'hC00000, 24'hA00000, 1'b0, 1'b1, 3'b000, 8'd127, 32'h3E800000, 5, 3'b000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
